// File: rtl/prod_acc_pkg.sv
// Shared types, default parameters and saturating-add helper for the
// product accumulator.
package prod_acc_pkg;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_t;

  localparam int PROD_W_DFLT  = 16;
  localparam int N_TERMS_DFLT = 4;
  localparam int ACC_W_DFLT   = 18;
  localparam int CNT_W_DFLT   = 8;

  // Working width of the helper; any ACC_W up to this is supported.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] sum;
  } sat_res_t;

  // Adds two zero-extended operands and clamps to all-ones of 'width' bits.
  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] acc,
                                       input logic [SAT_W-1:0] prod,
                                       input int               width);
    logic [SAT_W:0] one;
    logic [SAT_W:0] full;
    logic [SAT_W:0] limit;
    sat_res_t       res;
    one   = {{SAT_W{1'b0}}, 1'b1};
    full  = {1'b0, acc} + {1'b0, prod};
    limit = (one << width) - one;
    if (full > limit) begin
      res.sat = 1'b1;
      res.sum = limit[SAT_W-1:0];
    end else begin
      res.sat = 1'b0;
      res.sum = full[SAT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/prod_accumulator.sv
// Sums each group of N_TERMS valid products from the multiplier and presents
// the saturated group sum on a valid/ready output with overrun detection.
// The input is never back-pressured: a result that finds the output register
// still occupied is dropped and flagged.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DFLT,
  parameter int N_TERMS = N_TERMS_DFLT,
  parameter int ACC_W   = ACC_W_DFLT,
  parameter int CNT_W   = CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat,
  output logic              out_overrun,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             osat_q, osat_d;
  logic             overrun_q, overrun_d;

  sat_res_t         add_res;
  logic [ACC_W-1:0] add_sum;
  logic             add_sat;
  logic             complete;

  // Running sum plus the incoming product; acc is zero while idle, so the
  // same adder also serves the first term of a group.
  always_comb begin
    add_res  = sat_add(SAT_W'(acc_q), SAT_W'(in_prod), ACC_W);
    add_sum  = add_res.sum[ACC_W-1:0];
    add_sat  = add_res.sat;
    complete = in_valid && !clear && (state_q == ACC_RUN) && (cnt_q == LAST_CNT);
  end

  // Next-state logic for the group FSM and the output holding register.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    sum_d     = sum_q;
    osat_d    = osat_q;
    overrun_d = overrun_q;

    if (clear) begin
      state_d   = ACC_IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      sat_d     = 1'b0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (in_valid) begin
        case (state_q)
          ACC_IDLE: begin
            acc_d   = add_sum;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            sat_d   = add_sat;
            state_d = ACC_RUN;
          end
          ACC_RUN: begin
            if (complete) begin
              acc_d   = '0;
              cnt_d   = '0;
              sat_d   = 1'b0;
              state_d = ACC_IDLE;
            end else begin
              acc_d = add_sum;
              cnt_d = cnt_q + 1'b1;
              sat_d = sat_q | add_sat;
            end
          end
          default: state_d = ACC_IDLE;
        endcase
      end

      // A transfer frees the register; a completion on the same edge refills it.
      if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end
      if (complete) begin
        if (!valid_q || out_ready) begin
          valid_d = 1'b1;
          sum_d   = add_sum;
          osat_d  = sat_q | add_sat;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      state_q   <= ACC_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      sum_q     <= '0;
      osat_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      sum_q     <= sum_d;
      osat_q    <= osat_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_sum     = sum_q;
  assign out_sat     = osat_q;
  assign out_overrun = overrun_q;
  assign out_count   = cnt_q;
  assign busy        = (cnt_q != '0);

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed self-checking bench for prod_accumulator. A second instance with
// ACC_W=17 shares the stimulus and is only checked in the saturation step.
module tb_prod_accumulator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        clear;
  logic        out_ready;

  logic        out_valid, out_sat, out_overrun, busy;
  logic [17:0] out_sum;
  logic [7:0]  out_count;

  logic        v17, sat17, ovr17, busy17;
  logic [16:0] sum17;
  logic [7:0]  cnt17;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prod_accumulator dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_prod(in_prod),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat),
    .out_overrun(out_overrun), .busy(busy)
  );

  prod_accumulator #(.ACC_W(17)) dut17 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_prod(in_prod),
    .clear(clear), .out_valid(v17), .out_ready(out_ready),
    .out_sum(sum17), .out_count(cnt17), .out_sat(sat17),
    .out_overrun(ovr17), .busy(busy17)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one input beat, then return at the following negedge (after the
  // posedge has consumed it) so outputs are sampled mid-cycle.
  task automatic cyc(input logic v, input logic [15:0] p);
    in_valid = v;
    in_prod  = p;
    @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid",   32'(out_valid), 0);
    check("rst_sum",     32'(out_sum), 0);
    check("rst_count",   32'(out_count), 0);
    check("rst_busy",    32'(busy), 0);
    check("rst_sat",     32'(out_sat), 0);
    check("rst_overrun", 32'(out_overrun), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic group 100+200+300+400.
    cyc(1'b1, 16'd100);
    check("basic_cnt1", 32'(out_count), 1);
    check("basic_busy", 32'(busy), 1);
    cyc(1'b1, 16'd200);
    cyc(1'b1, 16'd300);
    check("basic_novalid", 32'(out_valid), 0);
    cyc(1'b1, 16'd400);
    check("basic_valid", 32'(out_valid), 1);
    check("basic_sum",   32'(out_sum), 1000);
    check("basic_sat",   32'(out_sat), 0);
    check("basic_cnt0",  32'(out_count), 0);
    check("basic_idle",  32'(busy), 0);
    cyc(1'b0, 16'd0);
    check("basic_taken", 32'(out_valid), 0);

    // Gapped group 5, gap x3, 7, gap, 9, 11.
    cyc(1'b1, 16'd5);
    check("gap_cnt1", 32'(out_count), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 16'd0);
      check("gap_busy1", 32'(busy), 1);
      check("gap_hold1", 32'(out_count), 1);
    end
    cyc(1'b1, 16'd7);
    check("gap_cnt2", 32'(out_count), 2);
    cyc(1'b0, 16'd0);
    check("gap_busy2", 32'(busy), 1);
    cyc(1'b1, 16'd9);
    check("gap_cnt3", 32'(out_count), 3);
    cyc(1'b1, 16'd11);
    check("gap_valid", 32'(out_valid), 1);
    check("gap_sum",   32'(out_sum), 32);
    check("gap_cnt0",  32'(out_count), 0);
    cyc(1'b0, 16'd0);

    // Saturation on the 17-bit instance; the 18-bit one holds the true sum.
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'hFFFF);
    check("sat17_valid", 32'(v17), 1);
    check("sat17_sum",   32'(sum17), 131071);
    check("sat17_flag",  32'(sat17), 1);
    check("sat18_sum",   32'(out_sum), 262140);
    check("sat18_flag",  32'(out_sat), 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'd1);
    check("unsat17_sum",  32'(sum17), 4);
    check("unsat17_flag", 32'(sat17), 0);
    cyc(1'b0, 16'd0);

    // Back-pressure: B completes while A is still pending.
    out_ready = 1'b0;
    cyc(1'b1, 16'd1); cyc(1'b1, 16'd2); cyc(1'b1, 16'd3); cyc(1'b1, 16'd4);
    check("bp_a_valid", 32'(out_valid), 1);
    check("bp_a_sum",   32'(out_sum), 10);
    check("bp_no_ovr",  32'(out_overrun), 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'd10);
    check("bp_hold_valid", 32'(out_valid), 1);
    check("bp_hold_sum",   32'(out_sum), 10);
    check("bp_overrun",    32'(out_overrun), 1);
    out_ready = 1'b1;
    cyc(1'b0, 16'd0);
    check("bp_drain",       32'(out_valid), 0);
    check("bp_ovr_sticky",  32'(out_overrun), 1);
    clear = 1'b1;
    cyc(1'b0, 16'd0);
    clear = 1'b0;
    check("bp_ovr_cleared", 32'(out_overrun), 0);

    // Accept and complete on the same edge.
    out_ready = 1'b0;
    cyc(1'b1, 16'd1); cyc(1'b1, 16'd2); cyc(1'b1, 16'd3); cyc(1'b1, 16'd4);
    cyc(1'b1, 16'd10); cyc(1'b1, 16'd10); cyc(1'b1, 16'd10);
    check("sim_pending_sum", 32'(out_sum), 10);
    out_ready = 1'b1;
    cyc(1'b1, 16'd10);
    check("sim_valid",   32'(out_valid), 1);
    check("sim_sum",     32'(out_sum), 40);
    check("sim_overrun", 32'(out_overrun), 0);
    cyc(1'b0, 16'd0);
    check("sim_drain", 32'(out_valid), 0);

    // clear mid-group, with a same-cycle product that must be discarded.
    cyc(1'b1, 16'd3); cyc(1'b1, 16'd3);
    check("clr_cnt2", 32'(out_count), 2);
    clear = 1'b1;
    cyc(1'b1, 16'd50);
    clear = 1'b0;
    check("clr_cnt0",  32'(out_count), 0);
    check("clr_busy",  32'(busy), 0);
    check("clr_valid", 32'(out_valid), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'd1);
    check("clr_next_sum",   32'(out_sum), 4);
    check("clr_next_valid", 32'(out_valid), 1);
    clear = 1'b1;
    cyc(1'b0, 16'd0);
    clear = 1'b0;
    check("clr_drops_valid", 32'(out_valid), 0);

    // Asynchronous reset between edges with a pending result and partial group.
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'd1);
    cyc(1'b1, 16'd9); cyc(1'b1, 16'd9);
    check("ar_pre_valid", 32'(out_valid), 1);
    check("ar_pre_cnt",   32'(out_count), 2);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 0);
    check("ar_sum",   32'(out_sum), 0);
    check("ar_cnt",   32'(out_count), 0);
    check("ar_busy",  32'(busy), 0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'd2);
    check("ar_after_sum",   32'(out_sum), 8);
    check("ar_after_valid", 32'(out_valid), 1);
    check("ar_after_ovr",   32'(out_overrun), 0);
    cyc(1'b0, 16'd0);

    // All-zero group is still a valid result.
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'd0);
    check("zero_valid", 32'(out_valid), 1);
    check("zero_sum",   32'(out_sum), 0);
    cyc(1'b0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
